// File: rtl/Dilithium_pkg.sv
//------------------------------------------------------------------------------
// Module   : Dilithium_pkg
// Brief    : Shared Dilithium sizes and the poly_pack state encoding.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package Dilithium_pkg;

  localparam int N       = 256;
  localparam int k       = 4;
  localparam int l       = 4;
  localparam int T1_BITS = 10;
  localparam int T0_BITS = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    DONE = 2'd2
  } poly_pack_state_t;

endpackage

`default_nettype wire

// File: rtl/poly_pack_bit_accumulator.sv
//------------------------------------------------------------------------------
// Module   : bit_accumulator
// Brief    : LSB-first bit accumulator; shift-out of 64 bits happens before insert.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bit_accumulator #(
  parameter int COEFF_BITS = 10,
  parameter int FILL_W     = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  ins_en,
  input  logic [COEFF_BITS-1:0] ins_data,
  input  logic                  shift_en,
  output logic [63:0]           word,
  output logic [FILL_W-1:0]     fill
);

  localparam int ACC_W = 64 + COEFF_BITS - 1;

  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  w_acc_sh;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic [FILL_W-1:0] r_fill;
  logic [FILL_W-1:0] w_fill_sh;
  logic [FILL_W-1:0] w_fill_nxt;

  always_comb begin
    w_acc_sh   = shift_en ? (r_acc >> 64) : r_acc;
    w_fill_sh  = shift_en ? (r_fill - FILL_W'(64)) : r_fill;
    w_acc_nxt  = w_acc_sh;
    w_fill_nxt = w_fill_sh;
    if (ins_en) begin
      w_acc_nxt  = w_acc_sh | (ACC_W'(ins_data) << w_fill_sh);
      w_fill_nxt = w_fill_sh + FILL_W'(COEFF_BITS);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc  <= '0;
      r_fill <= '0;
    end else if (clear) begin
      r_acc  <= '0;
      r_fill <= '0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_fill <= w_fill_nxt;
    end
  end

  assign word = r_acc[63:0];
  assign fill = r_fill;

endmodule

`default_nettype wire

// File: rtl/poly_pack.sv
//------------------------------------------------------------------------------
// Module   : poly_pack
// Brief    : SimpleBitPack of NUM_POLYS x 256 coefficients into 64-bit words.
//            Optional range check enabled by macro POLY_PACK_RANGE_CHECK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module poly_pack
  import Dilithium_pkg::*;
#(
  parameter int COEFF_BITS = 10,
  parameter int OUT_W      = 64,
  parameter int NUM_POLYS  = k
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [31:0]      in_coeff,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int FILL_W = $clog2(64 + COEFF_BITS);
  localparam int PC_W   = (NUM_POLYS > 1) ? $clog2(NUM_POLYS) : 1;

  poly_pack_state_t  r_state;
  poly_pack_state_t  w_state_nxt;
  logic [8:0]        r_coeff_cnt;
  logic [PC_W-1:0]   r_poly_cnt;
  logic [FILL_W-1:0] w_fill;
  logic [63:0]       w_word;
  logic              w_start_acc;
  logic              w_accept;
  logic              w_out_hs;
  logic              w_last_hs;

  assign w_start_acc = start && (r_state == IDLE);
  assign w_accept    = in_valid && in_ready;
  assign w_out_hs    = out_valid && out_ready;
  assign w_last_hs   = w_out_hs && out_last;

  bit_accumulator #(
    .COEFF_BITS (COEFF_BITS),
    .FILL_W     (FILL_W)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clear    (w_start_acc),
    .ins_en   (w_accept),
    .ins_data (in_coeff[COEFF_BITS-1:0]),
    .shift_en (w_out_hs),
    .word     (w_word),
    .fill     (w_fill)
  );

  // Output side is driven purely from registered fill, so it holds under backpressure.
  assign out_valid = (w_fill >= FILL_W'(64));
  assign out_data  = w_word;
  assign out_last  = out_valid && (r_coeff_cnt == 9'd256) && (w_fill == FILL_W'(64));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = PACK;
      PACK:    if (w_last_hs && (r_poly_cnt == PC_W'(NUM_POLYS - 1))) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == PACK) && (w_fill < FILL_W'(64)) && (r_coeff_cnt < 9'd256);
    busy     = (r_state != IDLE);
    done     = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_coeff_cnt <= '0;
      r_poly_cnt  <= '0;
    end else if (w_start_acc) begin
      r_coeff_cnt <= '0;
      r_poly_cnt  <= '0;
    end else if (w_last_hs) begin
      r_coeff_cnt <= '0;
      r_poly_cnt  <= r_poly_cnt + PC_W'(1);
    end else if (w_accept) begin
      r_coeff_cnt <= r_coeff_cnt + 9'd1;
    end
  end

`ifdef POLY_PACK_RANGE_CHECK_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else if (w_start_acc) begin
      r_err <= 1'b0;
    end else if (w_accept && (|in_coeff[31:COEFF_BITS])) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  // Upper coefficient bits are discarded when the range check is compiled out.
  logic w_unused_hi;
  assign w_unused_hi = |in_coeff[31:COEFF_BITS];
  assign err         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/poly_pack.md
POLY_PACK -- requirements
Module: poly_pack

Interface
REQ-001 Parameter COEFF_BITS, default 10, is the packed bit width per coefficient; the range is 1..23.
REQ-002 Parameter OUT_W, default 64, is the output word width and is fixed at 64.
REQ-003 Parameter NUM_POLYS, default k from Dilithium_pkg, is the number of 256-coefficient polynomials per job.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  single-cycle job start pulse.
REQ-007 in_valid  input  1  in_coeff is valid.
REQ-008 in_coeff  input  32  coefficient; only bits [COEFF_BITS-1:0] are packed.
REQ-009 in_ready  output  1  the block accepts in_coeff this cycle.
REQ-010 out_valid  output  1  out_data holds a complete packed word.
REQ-011 out_data  output  OUT_W  packed word.
REQ-012 out_last  output  1  marks the final word of the current polynomial.
REQ-013 out_ready  input  1  the downstream accepts out_data.
REQ-014 busy  output  1  the state is not IDLE.
REQ-015 done  output  1  one-cycle pulse when the job completes.
REQ-016 err  output  1  sticky range-check flag (see Configuration).

Function
REQ-017 The block SHALL implement SimpleBitPack: coefficient i of a polynomial occupies stream bits [i*COEFF_BITS +: COEFF_BITS]; word j of a polynomial is stream bits [64j +: 64]; ordering is LSB-first.
REQ-018 The state machine SHALL have three states: IDLE; PACK; DONE.
  - IDLE -> PACK on start, which clears all counters and err.
  - PACK -> DONE after the final word of polynomial NUM_POLYS-1 handshakes.
  - DONE -> IDLE unconditionally on the next cycle.
REQ-019 The block SHALL ignore start outside IDLE.
REQ-020 A coefficient SHALL be accepted when in_valid and in_ready are both high.
  - in_ready = (state==PACK) and (fill < 64) and (coeff_cnt < 256).
  - in_ready SHALL NOT depend combinationally on out_ready.
REQ-021 On accept, the coefficient SHALL be ORed into the accumulator at bit position fill; fill += COEFF_BITS; coeff_cnt += 1.
REQ-022 out_valid SHALL be high exactly when fill >= 64, with out_data = acc[63:0].
REQ-023 Output handshake: on out_valid and out_ready, the accumulator SHALL shift right by 64 and fill -= 64.
REQ-024 If an accept and an output handshake occur in the same cycle, the shift SHALL apply before the insert, so the new coefficient lands at position fill-64.
REQ-025 out_valid, out_data and out_last SHALL hold stable while out_ready is low.
REQ-026 The accumulator SHALL be 64+COEFF_BITS-1 bits wide; fill never exceeds 63+COEFF_BITS.
REQ-027 out_last SHALL be high with out_valid when coeff_cnt==256 and fill==64; fill is always 0 after it, since 256*COEFF_BITS is a multiple of 64.
REQ-028 On the out_last handshake, coeff_cnt SHALL reset to 0 and poly_cnt SHALL increment.
REQ-029 Each polynomial SHALL produce exactly 4*COEFF_BITS words, e.g. 40 for t1.
REQ-030 done SHALL be asserted only in state DONE; busy SHALL be high in PACK and DONE.

Reset
REQ-031 On rst low, asynchronously: state=IDLE; acc=0; fill=0; coeff_cnt=0; poly_cnt=0; in_ready=0; out_valid=0; out_data=0; out_last=0; busy=0; done=0; err=0.
REQ-032 A reset asserted mid-job SHALL abort the job; no partial word or done pulse SHALL appear after release.

Configuration
REQ-033 The macro is POLY_PACK_RANGE_CHECK_EN.
  - Defined: an accepted coefficient with any nonzero bit at or above COEFF_BITS SHALL set err, which stays set until the next accepted start or reset; the coefficient is still packed, truncated to COEFF_BITS.
  - Undefined: err is tied to 0 and the upper bits are silently ignored.

Structure
REQ-034 Dilithium_pkg SHALL hold N=256, k, l, T1_BITS=10, T0_BITS=13, and typedef enum poly_pack_state_t {IDLE, PACK, DONE}.
REQ-035 A single sub-module, bit_accumulator, SHALL own acc, fill, insert and shift; poly_pack owns the FSM, counters and handshakes.

Verification
REQ-036 COEFF_BITS=10, NUM_POLYS=1, coefficients all 0x3FF, out_ready=1 -> 40 words of 0xFFFF_FFFF_FFFF_FFFF; out_last only on word 40; one done pulse.
REQ-037 COEFF_BITS=10, coefficient i = i -> first word 0x6014_0400_C020_0400.
REQ-038 out_ready held low for 20 cycles mid-poly -> in_ready drops once fill>=64; out_data stays stable; the full stream matches the golden model with no loss or duplication.
REQ-039 rst pulsed low at word 17 of 40, then start -> the fresh job's output is identical to a clean run; no stale word or done pulse.
REQ-040 With POLY_PACK_RANGE_CHECK_EN, coefficient 5 = 0x400 -> err=1 and its packed slot = 0; a second start clears err. Without the macro, err stays 0.
REQ-041 start pulsed during PACK, and NUM_POLYS=4 -> start is ignored; exactly 160 words; out_last at words 40/80/120/160; done exactly once.
